fifo_rr_arbiter: RTL and testbench
==================================

FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, is the number of requester FIFOs (2..16).
REQ-002 Parameter DWIDTH, default 32, is the data word width.
REQ-003 Parameter BURST_LEN, default 4, is the maximum number of consecutive words popped from one port per grant (1..255).
REQ-004 Parameter SEL_W, default $clog2(NUM_PORTS), is the port-index width.
REQ-005 clk_i  input  1  is the single clock; all state changes on its rising edge.
REQ-006 arst_i  input  1  is the reset, asynchronous and active-high.
REQ-007 empty_i  input  NUM_PORTS  is the per-port FIFO empty flag; bit n low means q_i[n] holds a valid word.
REQ-008 q_i  input  NUM_PORTS x DWIDTH  is the per-port FIFO head word, show-ahead.
REQ-009 rdreq_o  output  NUM_PORTS  is the per-port pop strobe, one-hot or zero, combinational.
REQ-010 port_en_i  input  NUM_PORTS  is the per-port arbitration enable mask.
REQ-011 data_o  output  DWIDTH  is the registered output word.
REQ-012 valid_o  output  1  indicates data_o holds a valid word.
REQ-013 ready_i  input  1  is the downstream accept; a transfer occurs when valid_o and ready_i are both high.
REQ-014 sel_o  output  SEL_W  is the source port index of data_o.
REQ-015 busy_o  output  1  is high while the FSM is in GRANT.

Function
REQ-016 The FSM SHALL have two states: IDLE and GRANT; grant index g and last-served index last are registered.
REQ-017 A port n SHALL be eligible when empty_i[n]==0 and port_en_i[n]==1.
REQ-018 In IDLE, when any port is eligible, the FSM SHALL select the first eligible port searching last+1, last+2, ... modulo NUM_PORTS, load g with it, clear burst_cnt, and enter GRANT on the next edge; IDLE SHALL never assert rdreq_o.
REQ-019 The output stage SHALL be loadable (load_ok) when valid_o==0 or ready_i==1.
REQ-020 In GRANT, rdreq_o[g] SHALL be 1 in a cycle where port g is eligible and load_ok==1; all other rdreq_o bits SHALL be 0.
REQ-021 On each pop, data_o SHALL load q_i[g], sel_o SHALL load g, valid_o SHALL be set, and burst_cnt SHALL increment.
REQ-022 In a cycle with valid_o==1, ready_i==1 and no pop, valid_o SHALL clear; data_o and sel_o SHALL hold.
REQ-023 With valid_o==1 and ready_i==0, data_o, sel_o, and valid_o SHALL hold unchanged, and no pop SHALL occur.
REQ-024 GRANT SHALL exit to IDLE and set last to g on the edge of the pop that makes burst_cnt equal BURST_LEN.
REQ-025 GRANT SHALL exit to IDLE, set last to g, and not pop when port g is not eligible (empty or disabled), regardless of load_ok.
REQ-026 During a stall with port g eligible, the FSM SHALL remain in GRANT and burst_cnt SHALL hold.
REQ-027 burst_cnt SHALL be $clog2(BURST_LEN+1) bits wide and SHALL never exceed BURST_LEN.
REQ-028 last SHALL wrap from NUM_PORTS-1 to 0 in the search; indices >= NUM_PORTS SHALL never be granted.
REQ-029 Each burst SHALL pay a one-cycle arbitration bubble in IDLE; the first pop SHALL occur at earliest one cycle after IDLE sees eligibility.
REQ-030 No word SHALL be popped without being placed in data_o, and no word in data_o SHALL be overwritten before transfer.

Reset
REQ-031 While arst_i is high, state SHALL be IDLE, last SHALL be NUM_PORTS-1, g and burst_cnt SHALL be 0, valid_o SHALL be 0, data_o SHALL be 0, sel_o SHALL be 0, busy_o SHALL be 0, and rdreq_o SHALL be all zero.
REQ-032 Reset asserted mid-burst SHALL discard the held output word immediately, and after release port 0 SHALL have first priority.

Verification
REQ-033 Ports 0..3 each hold 6 words, ready_i=1 constantly, BURST_LEN=4 -> sel_o order 0x4,1x4,2x4,3x4,0x2,1x2,2x2,3x2; one bubble between bursts.
REQ-034 Port 2 holds 2 words, others empty -> exactly 2 pops on rdreq_o[2], GRANT exits on empty, busy_o low 1 cycle later.
REQ-035 Port 1 streaming, ready_i held low for 5 cycles mid-burst -> data_o/sel_o stable, rdreq_o zero throughout the stall, no word lost or duplicated.
REQ-036 port_en_i[0] cleared while port 0 is granted -> no further pop from port 0, next grant goes to port 1.
REQ-037 arst_i pulsed for 1 cycle mid-burst from port 3 -> valid_o=0 immediately, first post-reset grant goes to port 0.

Source files
------------

// File: rtl/fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rr_arbiter
// Description : Round-robin burst arbiter that drains up to NUM_PORTS
//               show-ahead FIFOs into one registered valid/ready output
//               stage. Each grant pops at most BURST_LEN consecutive words
//               from one port. The search for the next port starts just
//               after the last port served, so every port gets a fair turn.
//
// Ports
//   clk_i      in   1                   rising-edge clock
//   arst_i     in   1                   asynchronous active-high reset
//   empty_i    in   NUM_PORTS           per-port FIFO empty flag
//   q_i        in   NUM_PORTS*DWIDTH    per-port FIFO head words (port n at
//                                       bits [n*DWIDTH +: DWIDTH])
//   rdreq_o    out  NUM_PORTS           per-port pop strobe (one-hot or zero)
//   port_en_i  in   NUM_PORTS           per-port arbitration enable
//   data_o     out  DWIDTH              registered output word
//   valid_o    out  1                   data_o holds a valid word
//   ready_i    in   1                   downstream accept
//   sel_o      out  SEL_W               source port of data_o
//   busy_o     out  1                   high while a grant is active
//
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rr_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int DWIDTH    = 32,
    parameter int BURST_LEN = 4,
    parameter int SEL_W     = $clog2(NUM_PORTS)
) (
    input  logic                        clk_i,
    input  logic                        arst_i,
    input  logic [NUM_PORTS-1:0]        empty_i,
    input  logic [NUM_PORTS*DWIDTH-1:0] q_i,
    output logic [NUM_PORTS-1:0]        rdreq_o,
    input  logic [NUM_PORTS-1:0]        port_en_i,
    output logic [DWIDTH-1:0]           data_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [SEL_W-1:0]            sel_o,
    output logic                        busy_o
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t             r_state;
    logic [SEL_W-1:0]   r_g;
    logic [SEL_W-1:0]   r_last;
    logic [CNT_W-1:0]   r_burst_cnt;
    logic [DWIDTH-1:0]  r_data;
    logic [SEL_W-1:0]   r_sel;
    logic               r_valid;
    logic               r_busy;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [NUM_PORTS-1:0] w_elig;
    logic                 w_elig_g;
    logic [DWIDTH-1:0]    w_q_g;
    logic                 w_load_ok;
    logic                 w_pop;
    logic                 w_found;
    logic [SEL_W-1:0]     w_next;
    logic [SEL_W-1:0]     w_idx;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_burst_done;

    assign w_elig    = ~empty_i & port_en_i;
    // The output stage can take a new word if it is empty or being drained.
    assign w_load_ok = ~r_valid | ready_i;

    // Eligibility and head word of the currently granted port. Ports are
    // matched by explicit comparison so an out-of-range r_g selects nothing.
    always_comb begin
        w_elig_g = 1'b0;
        w_q_g    = '0;
        for (int n = 0; n < NUM_PORTS; n++) begin
            if (r_g == SEL_W'(n)) begin
                w_elig_g = w_elig[n];
                w_q_g    = q_i[n*DWIDTH +: DWIDTH];
            end
        end
    end

    // A pop only ever happens in GRANT, from an eligible port, into an
    // output stage that is free this cycle. This guarantees every popped
    // word lands in data_o and no untransferred word is overwritten.
    assign w_pop = (r_state == ST_GRANT) && w_elig_g && w_load_ok;

    always_comb begin
        rdreq_o = '0;
        for (int n = 0; n < NUM_PORTS; n++) begin
            if (w_pop && (r_g == SEL_W'(n))) begin
                rdreq_o[n] = 1'b1;
            end
        end
    end

    // Round-robin search: last+1, last+2, ... wrapping modulo NUM_PORTS.
    // The final iteration revisits 'last' itself so a lone requester can
    // be served again back to back.
    always_comb begin
        w_found = 1'b0;
        w_next  = '0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            w_idx = SEL_W'((int'(r_last) + i) % NUM_PORTS);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_next  = w_idx;
            end
        end
    end

    assign w_cnt_nxt    = r_burst_cnt + CNT_W'(1);
    assign w_burst_done = (w_cnt_nxt == CNT_W'(BURST_LEN));

    // ------------------------------------------------------------------
    // FSM with registered output stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state     <= ST_IDLE;
            r_g         <= '0;
            r_last      <= SEL_W'(NUM_PORTS - 1);   // port 0 searched first
            r_burst_cnt <= '0;
            r_data      <= '0;
            r_sel       <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // Output stage: a pop overrides a simultaneous drain.
            if (w_pop) begin
                r_data  <= w_q_g;
                r_sel   <= r_g;
                r_valid <= 1'b1;
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    // One-cycle arbitration bubble: never pops here.
                    if (w_found) begin
                        r_g         <= w_next;
                        r_burst_cnt <= '0;
                        r_state     <= ST_GRANT;
                        r_busy      <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (!w_elig_g) begin
                        // Port ran dry or was disabled: give up the grant.
                        r_last  <= r_g;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_load_ok) begin
                        r_burst_cnt <= w_cnt_nxt;
                        if (w_burst_done) begin
                            r_last  <= r_g;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    // Otherwise stalled downstream: hold grant and count.
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign data_o  = r_data;
    assign sel_o   = r_sel;
    assign valid_o = r_valid;
    assign busy_o  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rr_arbiter
// Description : Self-checking bench for fifo_rr_arbiter. Per-port FIFOs are
//               modelled with queues that react to rdreq_o; expected output
//               words are queued in hand-computed order and a monitor
//               compares each accepted transfer against the queue head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int BL = 4;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              arst_i;
    logic [N-1:0]      empty_i;
    logic [N*DW-1:0]   q_i;
    logic [N-1:0]      rdreq_o;
    logic [N-1:0]      port_en_i;
    logic [DW-1:0]     data_o;
    logic              valid_o;
    logic              ready_i;
    logic [SW-1:0]     sel_o;
    logic              busy_o;

    fifo_rr_arbiter #(
        .NUM_PORTS (N),
        .DWIDTH    (DW),
        .BURST_LEN (BL),
        .SEL_W     (SW)
    ) dut (
        .clk_i     (clk),
        .arst_i    (arst_i),
        .empty_i   (empty_i),
        .q_i       (q_i),
        .rdreq_o   (rdreq_o),
        .port_en_i (port_en_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .sel_o     (sel_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0]    fq0[$];
    logic [DW-1:0]    fq1[$];
    logic [DW-1:0]    fq2[$];
    logic [DW-1:0]    fq3[$];
    logic [SW+DW-1:0] sb[$];
    int               pop_cnt[N];

    function automatic logic [DW-1:0] word(input int p, input int k);
        return 32'hA000_0000 | DW'(p << 8) | DW'(k);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Fill a port's FIFO with words k0..k0+n-1.
    task automatic load(input int p, input int k0, input int n);
        for (int k = k0; k < k0 + n; k++) begin
            case (p)
                0: fq0.push_back(word(p, k));
                1: fq1.push_back(word(p, k));
                2: fq2.push_back(word(p, k));
                default: fq3.push_back(word(p, k));
            endcase
        end
    endtask

    task automatic expect_words(input int p, input int k0, input int n);
        for (int k = k0; k < k0 + n; k++) sb.push_back({SW'(p), word(p, k)});
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input string name, input int budget);
        int c;
        c = 0;
        while (sb.size() != 0 && c < budget) begin
            tick();
            c++;
        end
        chk({name, "_drain_timeout"}, 64'(sb.size()), 64'd0);
    endtask

    // FIFO model: pop on the strobes seen at the edge, then present new heads.
    always @(posedge clk) begin
        logic [N-1:0] rq;
        rq = rdreq_o;
        #1;
        if (rq[0] && fq0.size() != 0) begin void'(fq0.pop_front()); pop_cnt[0]++; end
        if (rq[1] && fq1.size() != 0) begin void'(fq1.pop_front()); pop_cnt[1]++; end
        if (rq[2] && fq2.size() != 0) begin void'(fq2.pop_front()); pop_cnt[2]++; end
        if (rq[3] && fq3.size() != 0) begin void'(fq3.pop_front()); pop_cnt[3]++; end
        empty_i[0] = (fq0.size() == 0);
        empty_i[1] = (fq1.size() == 0);
        empty_i[2] = (fq2.size() == 0);
        empty_i[3] = (fq3.size() == 0);
        q_i[0*DW +: DW] = (fq0.size() != 0) ? fq0[0] : '0;
        q_i[1*DW +: DW] = (fq1.size() != 0) ? fq1[0] : '0;
        q_i[2*DW +: DW] = (fq2.size() != 0) ? fq2[0] : '0;
        q_i[3*DW +: DW] = (fq3.size() != 0) ? fq3[0] : '0;
    end

    // Monitor: protocol checks and scoreboard comparison on each transfer.
    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev_data;
    logic [SW-1:0] prev_sel;

    always @(negedge clk) begin
        if (arst_i) begin
            stall_prev = 1'b0;
        end else begin
            if (rdreq_o != '0) begin
                chk("rdreq_onehot", 64'($onehot(rdreq_o)), 64'd1);
                chk("rdreq_on_ineligible", 64'(rdreq_o & (empty_i | ~port_en_i)), 64'd0);
                chk("rdreq_while_idle", 64'(busy_o), 64'd1);
            end
            if (stall_prev) begin
                chk("stall_hold_valid", 64'(valid_o), 64'd1);
                chk("stall_hold_data", 64'(data_o), 64'(prev_data));
                chk("stall_hold_sel", 64'(sel_o), 64'(prev_sel));
            end
            if (valid_o && !ready_i) chk("rdreq_in_stall", 64'(rdreq_o), 64'd0);
            if (valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", 64'({sel_o, data_o}), 64'd0);
                end else begin
                    chk("xfer_sel_data", 64'({sel_o, data_o}), 64'(sb.pop_front()));
                end
            end
            stall_prev = valid_o && !ready_i;
            prev_data  = data_o;
            prev_sel   = sel_o;
        end
    end

    initial begin
        int base;
        int c;

        arst_i    = 1'b1;
        ready_i   = 1'b0;
        port_en_i = '1;
        empty_i   = '1;
        q_i       = '0;
        for (int i = 0; i < N; i++) pop_cnt[i] = 0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_data",  64'(data_o),  64'd0);
        chk("rst_sel",   64'(sel_o),   64'd0);
        chk("rst_busy",  64'(busy_o),  64'd0);
        chk("rst_rdreq", 64'(rdreq_o), 64'd0);
        tick();
        arst_i = 1'b0;

        // ---- round robin, four full ports, burst of 4 then remainders ----
        ready_i = 1'b1;
        for (int p = 0; p < N; p++) load(p, 0, 6);
        for (int p = 0; p < N; p++) expect_words(p, 0, 4);
        for (int p = 0; p < N; p++) expect_words(p, 4, 2);
        drain("rr", 400);

        // ---- single port with two words: exit on empty ----
        base = pop_cnt[2];
        load(2, 0, 2);
        expect_words(2, 0, 2);
        c = 0;
        while ((pop_cnt[2] - base) < 2 && c < 50) begin tick(); c++; end
        chk("p2_two_pops_timeout", 64'(pop_cnt[2] - base), 64'd2);
        @(negedge clk);
        chk("p2_busy_after_last_pop", 64'(busy_o), 64'd1);
        chk("p2_no_pop_on_empty", 64'(rdreq_o), 64'd0);
        @(negedge clk);
        chk("p2_busy_drop", 64'(busy_o), 64'd0);
        drain("p2", 50);
        repeat (3) tick();
        chk("p2_pop_total", 64'(pop_cnt[2] - base), 64'd2);

        // ---- downstream stall mid-burst on port 1 ----
        base = pop_cnt[1];
        load(1, 0, 8);
        expect_words(1, 0, 8);
        c = 0;
        while (sb.size() > 6 && c < 50) begin tick(); c++; end
        chk("stall_start_timeout", 64'(sb.size() <= 6), 64'd1);
        ready_i = 1'b0;
        repeat (5) tick();
        ready_i = 1'b1;
        drain("stall", 100);
        repeat (3) tick();
        chk("stall_pop_total", 64'(pop_cnt[1] - base), 64'd8);

        // ---- disable port 0 while it holds the grant ----
        base = pop_cnt[0];
        load(0, 0, 4);
        load(1, 8, 4);
        expect_words(0, 0, 2);
        expect_words(1, 8, 4);
        expect_words(0, 2, 2);
        c = 0;
        while ((pop_cnt[0] - base) < 2 && c < 50) begin tick(); c++; end
        port_en_i[0] = 1'b0;
        c = 0;
        while (sb.size() > 2 && c < 100) begin tick(); c++; end
        repeat (3) tick();
        chk("dis_p0_pops", 64'(pop_cnt[0] - base), 64'd2);
        chk("dis_p1_served", 64'(sb.size()), 64'd2);
        port_en_i[0] = 1'b1;
        drain("dis", 100);

        // ---- asynchronous reset mid-burst on port 3 ----
        ready_i = 1'b0;
        base = pop_cnt[3];
        load(3, 0, 4);
        c = 0;
        while ((pop_cnt[3] - base) < 1 && c < 50) begin tick(); c++; end
        chk("p3_first_pop", 64'(valid_o), 64'd1);
        load(0, 10, 1);
        tick();
        arst_i = 1'b1;
        #1;
        chk("arst_valid", 64'(valid_o), 64'd0);
        chk("arst_data",  64'(data_o),  64'd0);
        chk("arst_busy",  64'(busy_o),  64'd0);
        chk("arst_rdreq", 64'(rdreq_o), 64'd0);
        tick();
        arst_i = 1'b0;
        expect_words(0, 10, 1);
        expect_words(3, 1, 3);
        ready_i = 1'b1;
        drain("arst", 100);
        repeat (3) tick();
        chk("arst_p3_pops", 64'(pop_cnt[3] - base), 64'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
